chess_board_renderer: RTL and testbench
=======================================

// Module: chess_board_renderer
// PURPOSE
//  Pipelined 8x8 chessboard compositor driven by the VGA scan position. Holds board state
//  (64 piece codes) and fetches piece-sprite pixels from an external synchronous sprite ROM
//  bank and palette. Overlays square colours, a cursor border and a selection tint.
//  Sits between the VGA controller and the DAC pins.
// PARAMETERS
//  TILE      60        sprite/square edge in pixels (board = 8*TILE square)
//  BOARD_X0  80        left board edge, DrawX units
//  BOARD_Y0  0         top board edge, DrawY units
//  BORDER_W  3         cursor border thickness in pixels, 1..TILE/2
//  CW        4         bits per colour channel
//  LIGHT/DARK/SEL/CUR/BG  {3*CW}  RGB constants: light/dark square, select tint, cursor, background
// PORTS
//  vga_clk    in   1        pixel clock; DrawX advances by exactly 1 per cycle inside a line
//  reset_n    in   1        asynchronous active-low reset
//  DrawX      in   10       current pixel column
//  DrawY      in   10       current pixel row
//  blank      in   1        1 = visible pixel
//  sq_we      in   1        board write strobe
//  sq_idx     in   6        square written (row*8+col, row 0 = top)
//  sq_code    in   4        piece code: 0 empty, 1-6 white P N B R Q K, 7-12 black, 13-15 empty
//  clr        in   1        empty all 64 squares next edge
//  cursor_idx in   6        square carrying cursor border
//  sel_valid  in   1        selection tint enabled
//  sel_idx    in   6        selected square
//  rom_addr   out  log2(TILE*TILE)  sprite pixel address = oy*TILE + ox
//  rom_piece  out  4        sprite select for external ROM bank mux
//  rom_q      in   4        palette index, valid 1 cycle after rom_addr/rom_piece; 0 = transparent
//  pal_index  out  4        = rom_q (combinational into external palette)
//  pal_rgb    in   3*CW     palette colour for pal_index, combinational
//  red/green/blue out CW    registered pixel colour
// BEHAVIOUR
//  Reset: board loads standard start position (row0 black R N B Q K B N R, row1 black P,
//   row6 white P, row7 white R N B Q K B N R, rest 0); all pipeline regs, rom_addr,
//   rom_piece, RGB = 0.
//  Position tracking (S1), no dividers: at DrawX==BOARD_X0 ox<=0,col<=0; else if in board
//   ox++ and at ox==TILE-1 ox<=0,col++. At DrawX==0: DrawY==BOARD_Y0 -> oy,row<=0; else if
//   DrawY inside board, oy++ wrapping at TILE-1 with row++. in_board = X,Y inside 8*TILE square.
//  Pipeline, input pixel sampled at edge k:
//   k   S1: ox,oy,col,row,in_board,blank registered.
//   k+1 S2: code<=board[row*8+col]; rom_addr, rom_piece registered; flags forwarded.
//   k+2 S3: external ROM registers rom_q; flags forwarded.
//   k+3 RGB registered. Fixed latency 3 edges; blank/in_board delayed identically.
//  Colour priority at k+3: !blank -> 0; !in_board -> BG; cursor square and
//   (ox<BORDER_W|ox>=TILE-BORDER_W|oy<BORDER_W|oy>=TILE-BORDER_W) -> CUR; code in 1..12 and
//   rom_q!=0 -> pal_rgb; sel_valid and square==sel_idx -> SEL; (row+col) even -> LIGHT else DARK.
//  Board writes: sq_we updates entry at edge; same-cycle S2 read of that square returns old code.
//  clr and sq_we same edge: clr wins (all empty). Codes 13-15 render as empty.
//  Reset asserted mid-frame: outputs 0 immediately; tracking resyncs at next DrawX==BOARD_X0
//   and DrawY==BOARD_Y0; no output requirement for the partial frame after release.
// TESTING
//  Reset, scan full frame -> pixel (BOARD_X0,0) after 3 edges = LIGHT; square 0 fetches
//   rom_piece=10 (black R); pixel (BOARD_X0+TILE,0) = DARK when rom_q=0.
//  Drive blank=0 at pixel k -> RGB=0 exactly at edge k+3; pixel X=BOARD_X0-1 -> BG.
//  sq_we idx 36 code 5 -> rom_piece=5, rom_addr=oy*60+ox when scan is inside square 36.
//  cursor_idx=27, BORDER_W=3 -> ox=0..2 and 57..59 CUR; ox=3 LIGHT/DARK/sprite.
//  sel_valid idx 27, rom_q=0 -> SEL; rom_q=4 -> pal_rgb; cursor border beats both.
//  clr with sq_we same edge -> every square empty; reset mid-line -> RGB 0 instantly, correct next frame.

Source files
------------

// File: rtl/chess_board_renderer.sv
// Pipelined 8x8 chessboard compositor: tracks the VGA scan position, fetches sprite pixels
// from an external synchronous ROM and overlays square colours, cursor border and selection tint.
module chess_board_renderer #(
   parameter int unsigned       TILE     = 60,
   parameter int unsigned       BOARD_X0 = 80,
   parameter int unsigned       BOARD_Y0 = 0,
   parameter int unsigned       BORDER_W = 3,
   parameter int unsigned       CW       = 4,
   parameter logic [3*CW-1:0]   LIGHT    = 12'hEDB,
   parameter logic [3*CW-1:0]   DARK     = 12'h853,
   parameter logic [3*CW-1:0]   SEL      = 12'h6C6,
   parameter logic [3*CW-1:0]   CUR      = 12'hF00,
   parameter logic [3*CW-1:0]   BG       = 12'h222,
   localparam int unsigned      AW       = $clog2(TILE*TILE)
) (
   input  logic              vga_clk,
   input  logic              reset_n,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              blank,
   input  logic              sq_we,
   input  logic [5:0]        sq_idx,
   input  logic [3:0]        sq_code,
   input  logic              clr,
   input  logic [5:0]        cursor_idx,
   input  logic              sel_valid,
   input  logic [5:0]        sel_idx,
   output logic [AW-1:0]     rom_addr,
   output logic [3:0]        rom_piece,
   input  logic [3:0]        rom_q,
   output logic [3:0]        pal_index,
   input  logic [3*CW-1:0]   pal_rgb,
   output logic [CW-1:0]     red,
   output logic [CW-1:0]     green,
   output logic [CW-1:0]     blue
);

   localparam int unsigned OW   = $clog2(TILE);
   localparam int unsigned SPAN = 8 * TILE;
   localparam logic [OW-1:0] LAST = OW'(TILE - 1);
   localparam logic [OW-1:0] B_LO = OW'(BORDER_W);
   localparam logic [OW-1:0] B_HI = OW'(TILE - BORDER_W);

   function automatic logic [3:0] start_code(input int unsigned i);
      logic [3:0] back;
      case (i & 7)
         0, 7:    back = 4'd4;
         1, 6:    back = 4'd2;
         2, 5:    back = 4'd3;
         3:       back = 4'd5;
         default: back = 4'd6;
      endcase
      if (i < 8)       return back + 4'd6;
      else if (i < 16) return 4'd7;
      else if (i < 48) return 4'd0;
      else if (i < 56) return 4'd1;
      else             return back;
   endfunction

   logic [3:0] board_q [64];

   logic          x_in, y_in;
   logic [OW-1:0] ox1_q, oy1_q, ox2_q, oy2_q, ox3_q, oy3_q;
   logic [2:0]    col1_q, row1_q;
   logic [5:0]    sq2_q, sq3_q;
   logic          inb1_q, inb2_q, inb3_q;
   logic          blank1_q, blank2_q, blank3_q;
   logic [3:0]    code3_q;
   logic [3*CW-1:0] rgb_d, rgb_q;
   logic          border, piece;

   assign x_in = (DrawX >= 10'(BOARD_X0)) && ({1'b0, DrawX} < 11'(BOARD_X0 + SPAN));
   assign y_in = (DrawY >= 10'(BOARD_Y0)) && ({1'b0, DrawY} < 11'(BOARD_Y0 + SPAN));

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 64; i++) board_q[i] <= start_code(i);
      end else if (clr) begin
         for (int i = 0; i < 64; i++) board_q[i] <= '0;
      end else if (sq_we) begin
         board_q[sq_idx] <= sq_code;
      end
   end

   // S1: counter-based tile tracking, no dividers
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         ox1_q    <= '0;
         oy1_q    <= '0;
         col1_q   <= '0;
         row1_q   <= '0;
         inb1_q   <= 1'b0;
         blank1_q <= 1'b0;
      end else begin
         if (DrawX == 10'(BOARD_X0)) begin
            ox1_q  <= '0;
            col1_q <= '0;
         end else if (x_in) begin
            if (ox1_q == LAST) begin
               ox1_q  <= '0;
               col1_q <= col1_q + 3'd1;
            end else begin
               ox1_q <= ox1_q + OW'(1);
            end
         end
         if (DrawX == 10'd0) begin
            if (DrawY == 10'(BOARD_Y0)) begin
               oy1_q  <= '0;
               row1_q <= '0;
            end else if (y_in) begin
               if (oy1_q == LAST) begin
                  oy1_q  <= '0;
                  row1_q <= row1_q + 3'd1;
               end else begin
                  oy1_q <= oy1_q + OW'(1);
               end
            end
         end
         inb1_q   <= x_in && y_in;
         blank1_q <= blank;
      end
   end

   // S2 fetches the piece code and sprite address; S3 waits for the ROM's registered output
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         rom_addr  <= '0;
         rom_piece <= '0;
         ox2_q     <= '0;
         oy2_q     <= '0;
         sq2_q     <= '0;
         inb2_q    <= 1'b0;
         blank2_q  <= 1'b0;
         ox3_q     <= '0;
         oy3_q     <= '0;
         sq3_q     <= '0;
         inb3_q    <= 1'b0;
         blank3_q  <= 1'b0;
         code3_q   <= '0;
         rgb_q     <= '0;
      end else begin
         rom_addr  <= AW'(32'(oy1_q) * TILE + 32'(ox1_q));
         rom_piece <= board_q[{row1_q, col1_q}];
         ox2_q     <= ox1_q;
         oy2_q     <= oy1_q;
         sq2_q     <= {row1_q, col1_q};
         inb2_q    <= inb1_q;
         blank2_q  <= blank1_q;
         ox3_q     <= ox2_q;
         oy3_q     <= oy2_q;
         sq3_q     <= sq2_q;
         inb3_q    <= inb2_q;
         blank3_q  <= blank2_q;
         code3_q   <= rom_piece;
         rgb_q     <= rgb_d;
      end
   end

   assign border = (ox3_q < B_LO) || (ox3_q >= B_HI) || (oy3_q < B_LO) || (oy3_q >= B_HI);
   assign piece  = (code3_q != 4'd0) && (code3_q <= 4'd12);

   always_comb begin
      rgb_d = '0;
      if (!blank3_q) begin
         rgb_d = '0;
      end else if (!inb3_q) begin
         rgb_d = BG;
      end else if ((sq3_q == cursor_idx) && border) begin
         rgb_d = CUR;
      end else if (piece && (rom_q != 4'd0)) begin
         rgb_d = pal_rgb;
      end else if (sel_valid && (sq3_q == sel_idx)) begin
         rgb_d = SEL;
      end else if ((sq3_q[3] ^ sq3_q[0]) == 1'b0) begin
         rgb_d = LIGHT;
      end else begin
         rgb_d = DARK;
      end
   end

   assign pal_index = rom_q;
   assign red       = rgb_q[3*CW-1:2*CW];
   assign green     = rgb_q[2*CW-1:CW];
   assign blue      = rgb_q[CW-1:0];

endmodule

// File: tb/tb_chess_board_renderer.sv
// Directed bench for chess_board_renderer: scoreboard of expected pixels compared 3 edges later.
module tb_chess_board_renderer;

   localparam int T  = 60;
   localparam int X0 = 80;
   localparam int Y0 = 0;
   localparam int BW = 3;
   localparam logic [11:0] C_LIGHT = 12'hEDB;
   localparam logic [11:0] C_DARK  = 12'h853;
   localparam logic [11:0] C_SEL   = 12'h6C6;
   localparam logic [11:0] C_CUR   = 12'hF00;
   localparam logic [11:0] C_BG    = 12'h222;

   logic        vga_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [9:0]  DrawX = '0, DrawY = '0;
   logic        blank = 1'b0;
   logic        sq_we = 1'b0;
   logic [5:0]  sq_idx = '0;
   logic [3:0]  sq_code = '0;
   logic        clr = 1'b0;
   logic [5:0]  cursor_idx = 6'd63;
   logic        sel_valid = 1'b0;
   logic [5:0]  sel_idx = '0;
   logic [11:0] rom_addr;
   logic [3:0]  rom_piece;
   logic [3:0]  rom_q = '0;
   logic [3:0]  pal_index;
   logic [11:0] pal_rgb;
   logic [3:0]  red, green, blue;

   int rom_mode = 0;
   int bm [64];
   int n_cmp = 0;
   int n_err = 0;

   typedef struct {int x; int y; logic [11:0] rgb;} exp_t;
   exp_t sb [$];

   function automatic logic [11:0] pal_fn(input logic [3:0] i);
      return {i, i ^ 4'hA, ~i};
   endfunction

   assign pal_rgb = pal_fn(pal_index);

   always #5 vga_clk = ~vga_clk;

   // synchronous sprite ROM stand-in
   always @(posedge vga_clk) begin
      if (rom_mode == 0)      rom_q <= 4'd0;
      else if (rom_mode == 1) rom_q <= 4'd4;
      else                    rom_q <= rom_addr[3:0];
   end

   chess_board_renderer #(
      .TILE(T), .BOARD_X0(X0), .BOARD_Y0(Y0), .BORDER_W(BW), .CW(4),
      .LIGHT(C_LIGHT), .DARK(C_DARK), .SEL(C_SEL), .CUR(C_CUR), .BG(C_BG)
   ) dut (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .sq_we(sq_we), .sq_idx(sq_idx), .sq_code(sq_code), .clr(clr),
      .cursor_idx(cursor_idx), .sel_valid(sel_valid), .sel_idx(sel_idx),
      .rom_addr(rom_addr), .rom_piece(rom_piece), .rom_q(rom_q),
      .pal_index(pal_index), .pal_rgb(pal_rgb), .red(red), .green(green), .blue(blue)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic init_board();
      int back [8];
      back = '{4, 2, 3, 5, 6, 3, 2, 4};
      for (int i = 0; i < 64; i++) bm[i] = 0;
      for (int i = 0; i < 8; i++) begin
         bm[i]      = back[i] + 6;
         bm[8 + i]  = 7;
         bm[48 + i] = 1;
         bm[56 + i] = back[i];
      end
   endtask

   function automatic logic [11:0] exp_px(input int x, input int y, input logic b);
      int ox, oy, col, row, sq, rq;
      logic brd;
      if (!b) return 12'h000;
      if (x < X0 || x >= X0 + 8*T || y < Y0 || y >= Y0 + 8*T) return C_BG;
      ox  = (x - X0) % T;
      col = (x - X0) / T;
      oy  = (y - Y0) % T;
      row = (y - Y0) / T;
      sq  = row * 8 + col;
      brd = (ox < BW) || (ox >= T - BW) || (oy < BW) || (oy >= T - BW);
      if (sq == int'(cursor_idx) && brd) return C_CUR;
      rq = (rom_mode == 0) ? 0 : (rom_mode == 1) ? 4 : (oy * T + ox) % 16;
      if (bm[sq] >= 1 && bm[sq] <= 12 && rq != 0) return pal_fn(4'(rq));
      if (sel_valid && sq == int'(sel_idx)) return C_SEL;
      return ((row + col) % 2 == 0) ? C_LIGHT : C_DARK;
   endfunction

   task automatic step(input int x, input int y, input logic b);
      exp_t e;
      @(negedge vga_clk);
      if (sb.size() >= 4) begin
         e = sb.pop_front();
         check($sformatf("pixel(%0d,%0d)", e.x, e.y), {20'b0, red, green, blue}, {20'b0, e.rgb});
      end
      DrawX = 10'(x);
      DrawY = 10'(y);
      blank = b;
      e.x = x; e.y = y; e.rgb = exp_px(x, y, b);
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(799, int'(DrawY), 1'b0);
   endtask

   // DrawX=0 once per line from the top advances the row tracker to line y
   task automatic sync_to(input int y);
      for (int yy = 0; yy <= y; yy++) step(0, yy, 1'b1);
   endtask

   task automatic scan(input int y, input int xa, input int xb);
      for (int x = xa; x <= xb; x++) step(x, y, 1'b1);
   endtask

   task automatic write_sq(input int idx, input int code);
      sq_we = 1'b1; sq_idx = 6'(idx); sq_code = 4'(code);
      idle(1);
      sq_we = 1'b0;
      bm[idx] = code;
   endtask

   initial begin
      init_board();
      #12;
      check("reset_rgb", {20'b0, red, green, blue}, 32'h0);
      check("reset_rom_piece", {28'b0, rom_piece}, 32'h0);
      check("reset_rom_addr", {20'b0, rom_addr}, 32'h0);
      @(negedge vga_clk);
      reset_n = 1'b1;

      // row 0: background, light/dark squares, a single blanked pixel
      sync_to(0);
      for (int x = X0 - 1; x <= X0 + 61; x++) step(x, 0, x != X0 + 5);
      idle(4);
      scan(0, X0, X0 + 2);
      idle(2);
      check("sq0_rom_piece", {28'b0, rom_piece}, 32'd10);
      check("sq0_rom_addr", {20'b0, rom_addr}, 32'd2);
      idle(2);

      // white queen on square 36, sprite palette index taken from rom_addr
      write_sq(36, 5);
      rom_mode = 2;
      sync_to(245);
      scan(245, X0 - 1, X0 + 250);
      idle(2);
      check("sq36_rom_piece", {28'b0, rom_piece}, 32'd5);
      check("sq36_rom_addr", {20'b0, rom_addr}, 32'd310);
      idle(2);

      // cursor border and selection tint on square 27
      write_sq(27, 3);
      cursor_idx = 6'd27;
      sel_idx    = 6'd27;
      sel_valid  = 1'b1;
      rom_mode   = 1;
      sync_to(200);
      scan(200, X0 - 1, X0 + 245);
      idle(4);
      rom_mode = 0;
      sync_to(200);
      scan(200, X0 - 1, X0 + 245);
      idle(4);
      sync_to(181);
      scan(181, X0 - 1, X0 + 245);
      idle(4);

      // clear beats a same-edge write; codes 13-15 render empty
      clr = 1'b1; sq_we = 1'b1; sq_idx = 6'd0; sq_code = 4'd4;
      idle(1);
      clr = 1'b0; sq_we = 1'b0;
      for (int i = 0; i < 64; i++) bm[i] = 0;
      write_sq(1, 14);
      cursor_idx = 6'd63;
      rom_mode   = 1;
      sync_to(5);
      scan(5, X0 - 1, X0 + 8*T);
      idle(4);

      // reset asserted mid-line
      sync_to(10);
      scan(10, X0 - 1, X0 + 100);
      #2 reset_n = 1'b0;
      #1 check("midline_reset_rgb", {20'b0, red, green, blue}, 32'h0);
      sb.delete();
      init_board();
      @(negedge vga_clk);
      @(negedge vga_clk);
      reset_n = 1'b1;
      sync_to(0);
      scan(0, X0 - 1, X0 + 130);
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
